// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns a stream of decoded instruction descriptors into
// RV32I instruction words and writes them into consecutive IMEM word addresses.
// Each session runs from a start pulse until the descriptor marked last, an
// illegal or misaligned descriptor, or the instruction memory filling up.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_fmt,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Session states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  // Descriptor format classes
  localparam logic [3:0] FMT_R      = 4'd0;
  localparam logic [3:0] FMT_I_ALU  = 4'd1;
  localparam logic [3:0] FMT_LOAD   = 4'd2;
  localparam logic [3:0] FMT_STORE  = 4'd3;
  localparam logic [3:0] FMT_BRANCH = 4'd4;
  localparam logic [3:0] FMT_JAL    = 4'd5;
  localparam logic [3:0] FMT_JALR   = 4'd6;
  localparam logic [3:0] FMT_LUI    = 4'd7;
  localparam logic [3:0] FMT_AUIPC  = 4'd8;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Abort reasons
  localparam logic [1:0] ERR_FMT   = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  localparam logic [ADDR_WIDTH+1:0] FILL_FULL = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] FILL_LAST = (ADDR_WIDTH+2)'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] next_addr;
  // A final word is in flight; the session closes once it has been written.
  logic                  close_pending;
  logic                  close_err;

  logic [ADDR_WIDTH+1:0] fill;
  logic                  handshake;
  logic                  fmt_illegal;
  logic                  misaligned;
  logic [31:0]           enc_word;

  // Words committed to this session: already counted plus the one being written.
  assign fill = {1'b0, count} + (ADDR_WIDTH+2)'(imem_we);

  assign busy        = (state == S_RUN);
  assign in_ready    = (state == S_RUN) && !start && !close_pending && (fill != FILL_FULL);
  assign handshake   = in_valid && in_ready;
  assign fmt_illegal = (in_fmt > FMT_AUIPC);
  assign misaligned  = ((in_fmt == FMT_BRANCH) || (in_fmt == FMT_JAL)) && in_imm[0];

  // Pack the descriptor fields into the RV32I layout of its format class.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    enc_word = '0;
    case (in_fmt)
      FMT_R:
        enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      FMT_I_ALU:
        if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
          // Shift-immediate: shamt in the rs2 slot, funct7 carries srai/srli.
          enc_word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd,
                      OP_I_ALU};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I_ALU};
        end
      FMT_LOAD:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      FMT_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      FMT_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                    in_imm[11], OP_BRANCH};
      FMT_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      FMT_JALR:
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      FMT_LUI:
        enc_word = {in_imm[31:12], in_rd, OP_LUI};
      FMT_AUIPC:
        enc_word = {in_imm[31:12], in_rd, OP_AUIPC};
      default:
        enc_word = '0;
    endcase
  end

  // Session control, write port registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the write data/address registers are reset as well, so the IMEM
      // port shows all zeros rather than X until the first write.
      state         <= S_IDLE;
      next_addr     <= '0;
      close_pending <= 1'b0;
      close_err     <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
      count         <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values; blocking ones would make order matter.
      imem_we <= 1'b0;
      if (imem_we) begin
        count <= count + 1'b1;
      end

      if (start) begin
        // Restart wins over anything in progress; a write registered last cycle
        // still reaches IMEM but is not counted for the new session.
        state         <= S_RUN;
        next_addr     <= ADDR_WIDTH'(BASE_ADDR);
        count         <= '0;
        done          <= 1'b0;
        err           <= 1'b0;
        err_code      <= '0;
        close_pending <= 1'b0;
        close_err     <= 1'b0;
      end else if (state == S_RUN) begin
        if (close_pending) begin
          // The final word is on the write port this cycle; close the session.
          close_pending <= 1'b0;
          if (close_err) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_OVF;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end else if (handshake) begin
          if (fmt_illegal) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_FMT;
          end else if (misaligned) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_ALIGN;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= next_addr;
            imem_wdata <= enc_word;
            next_addr  <= next_addr + 1'b1;
            if (in_last) begin
              close_pending <= 1'b1;
              close_err     <= 1'b0;
            end else if (fill == FILL_LAST) begin
              // This word fills the memory and the stream did not end here.
              close_pending <= 1'b1;
              close_err     <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader with a 4-word IMEM. Expected
// IMEM writes are queued when a descriptor is accepted and popped whenever the
// DUT raises imem_we.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_fmt;
  logic [2:0]    in_funct3;
  logic          in_funct7b5;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;

  instr_encoder_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_funct3  (in_funct3),
    .in_funct7b5(in_funct7b5),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .count      (count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] exp_addr;
  int            n_checks;
  int            n_fail;
  int            waits;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare any IMEM write against the head of the scoreboard.
  task automatic mon();
    wr_t w;
    if (imem_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(imem_we), 32'(0));
      end else begin
        w = sb.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    check("start_cycle_ready", 32'(in_ready), 32'(0));
    exp_addr = '0;
    step();
    start = 1'b0;
  endtask

  // Present one descriptor and wait (bounded) for it to be accepted.
  task automatic send(input string tag, input logic [3:0] fmt, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic exp_we, input logic [31:0] exp_word, input logic exp_acc);
    wr_t w;
    logic ok;
    in_valid = 1'b1;
    in_fmt = fmt; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        if (exp_we) begin
          w.addr = exp_addr;
          w.data = exp_word;
          sb.push_back(w);
          exp_addr = exp_addr + 1'b1;
        end
      end else begin
        waits++;
      end
      step();
    end
    check(tag, 32'(ok), 32'(exp_acc));
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic e,
                              input logic [1:0] code, input logic [AW:0] cnt);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_err_code"}, 32'(err_code), 32'(code));
    check({tag, "_count"}, 32'(count), 32'(cnt));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    n_checks = 0; n_fail = 0; waits = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_fmt = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(imem_we), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(0));
    check("rst_addr", 32'(imem_addr), 32'(0));
    check("rst_wdata", imem_wdata, 32'h0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 2'b00, '0);
    rst_n = 1'b1;
    step();

    // addi then add (last)
    do_start();
    check("run_busy", 32'(busy), 32'(1));
    send("acc_addi", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 1'b1);
    send("acc_add", 4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3, 1'b1);
    in_valid = 1'b0;
    check("t1_last_write_cycle_done", 32'(done), 32'(0));
    check("t1_last_write_cycle_busy", 32'(busy), 32'(1));
    check("t1_after_last_ready", 32'(in_ready), 32'(0));
    step();
    check_status("t1", 1'b0, 1'b1, 1'b0, 2'b00, 3'd2);

    // Back-to-back sub, sw, beq (last)
    do_start();
    waits = 0;
    send("acc_sub", 4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h402081B3, 1'b1);
    send("acc_sw", 4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423, 1'b1);
    send("acc_beq", 4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hFE000EE3,
         1'b1);
    in_valid = 1'b0;
    check("t2_b2b_waits", 32'(waits), 32'(0));
    step();
    check_status("t2", 1'b0, 1'b1, 1'b0, 2'b00, 3'd3);

    // jal, lui (last)
    do_start();
    send("acc_jal", 4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 1'b1, 32'h008000EF, 1'b1);
    send("acc_lui", 4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 32'h123452B7,
         1'b1);
    in_valid = 1'b0;
    step();
    check_status("t3", 1'b0, 1'b1, 1'b0, 2'b00, 3'd2);

    // srai, jalr (funct3 forced 0), auipc (low imm dropped), lw: fills DEPTH with last
    do_start();
    send("acc_srai", 4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0, 1'b1, 32'h40315093, 1'b1);
    send("acc_jalr", 4'd6, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 1'b1, 32'h004100E7, 1'b1);
    send("acc_auipc", 4'd8, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'hABCDE123, 1'b0, 1'b1, 32'hABCDE117,
         1'b1);
    send("acc_lw", 4'd2, 3'd2, 1'b0, 5'd3, 5'd1, 5'd0, 32'hFFFFFFF8, 1'b1, 1'b1, 32'hFF80A183,
         1'b1);
    in_valid = 1'b0;
    step();
    check_status("t4", 1'b0, 1'b1, 1'b0, 2'b00, 3'd4);

    // Illegal format on the second descriptor
    do_start();
    send("acc_addi2", 4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 1'b1);
    send("acc_illegal", 4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_status("t5", 1'b0, 1'b0, 1'b1, 2'b01, 3'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_err_hold_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0;

    // Overflow: five descriptors without last into a 4-word memory
    do_start();
    for (int k = 1; k <= 4; k++) begin
      send("acc_fill", 4'd1, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k), 1'b0, 1'b1,
           (32'(k) << 20) | (32'(k) << 7) | 32'h13, 1'b1);
    end
    send("rej_fifth", 4'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500293, 1'b0);
    in_valid = 1'b0;
    check_status("t6", 1'b0, 1'b0, 1'b1, 2'b11, 3'd4);

    // Misaligned branch target
    do_start();
    send("acc_misalign", 4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1, 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    step();
    check_status("t7", 1'b0, 1'b0, 1'b1, 2'b10, 3'd0);

    // Reset right after a handshake drops the in-flight word
    do_start();
    in_valid = 1'b1;
    in_fmt = 4'd1; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
    in_rd = 5'd7; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd9; in_last = 1'b1;
    #1;
    check("t8_ready_before_rst", 32'(in_ready), 32'(1));
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check("t8_rst_we", 32'(imem_we), 32'(0));
    check("t8_rst_ready", 32'(in_ready), 32'(0));
    check("t8_rst_addr", 32'(imem_addr), 32'(0));
    check("t8_rst_wdata", imem_wdata, 32'h0);
    check_status("t8_rst", 1'b0, 1'b0, 1'b0, 2'b00, '0);
    step();
    rst_n = 1'b1;
    step();

    // Start with a concurrent descriptor: held, then accepted at BASE_ADDR
    in_valid = 1'b1;
    do_start();
    send("acc_after_start", 4'd1, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd9, 1'b1, 1'b1, 32'h00900393,
         1'b1);
    in_valid = 1'b0;
    step();
    check_status("t9", 1'b0, 1'b1, 1'b0, 2'b00, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
